ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
Instruction-fetch sequencer in front of the combinational, byte-addressed, little-endian instruction ROM. Owns the PC, drives the ROM address, and captures each returned word with its PC into a small prefetch queue. Presents fetched instructions to decode over a valid/ready handshake. Handles branch/jump redirects (flush and refetch) and stops cleanly at the end of the ROM image.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ROM_BYTES, 128, size of the fetchable ROM in bytes; a word at PC is fetchable iff PC+4 <= ROM_BYTES
QDEPTH, 4, prefetch queue entries (power of two, >= 2)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_addr  out  32  byte address to ROM (= current PC)
imem_instr  in  32  ROM word at imem_addr, combinational, same cycle
redir_valid  in  1  redirect request from execute (taken branch, JAL, JALR)
redir_pc  in  32  redirect target
dec_valid  out  1  queue head holds a valid instruction
dec_ready  in  1  decode accepts head this cycle
dec_instr  out  32  head instruction
dec_pc  out  32  PC of head instruction
fetch_state  out  2  00 RUN, 01 END, 10 FAULT
fault_pc  out  32  offending redirect target when in FAULT

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, queue empty, state RUN, dec_valid=0, dec_instr=0, dec_pc=0, fault_pc=0, fetch_state=00.
- imem_addr = pc at all times, combinational.
- Fetch (RUN only): push {pc, imem_instr} and pc<=pc+4 when the queue has room, i.e. count<QDEPTH or a pop happens in the same cycle. Push-with-pop when full is permitted; count is unchanged.
- Latency: instruction at pc is visible at dec_* one cycle after the fetch cycle. Zero bubbles at steady state with dec_ready=1.
- Pop: dec_valid && dec_ready advances the head. dec_* show the head entry combinationally. dec_instr and dec_pc read 0 when the queue is empty.
- End of image: in RUN, if pc+4 > ROM_BYTES, do not push; state<=END. In END, drain the queue normally with no fetches.
- Redirect (highest priority, any state):
  - Flush the queue (count<=0), discarding any same-cycle push. A same-cycle pop is still accepted by decode.
  - If redir_pc[1:0]!=0 or redir_pc+4>ROM_BYTES: state<=FAULT, fault_pc<=redir_pc, pc unchanged.
  - Otherwise pc<=redir_pc and state<=RUN. The first post-redirect instruction appears at dec_* 2 cycles after redir_valid.
- FAULT: no fetch, dec_valid=0. Exit only via a valid redirect or reset.
- PC arithmetic is 32-bit modulo. The bound check uses a 33-bit compare so pc+4 near 2^32 does not wrap into range.
- Queue pointers are log2(QDEPTH) bits with wrap. Count is log2(QDEPTH)+1 bits.
- Reset mid-operation: everything returns to reset values immediately. No partial state survives.

Optional Feature:
Macro IFETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32), perf_flushed (32) and perf_stall (32), each reset to 0.
  - perf_fetched counts pushes.
  - perf_flushed adds the discarded queue count on each redirect.
  - perf_stall counts cycles with dec_valid=0 in state RUN.
  - All counters saturate at all-ones.
- Undefined: ports and counters absent; other behaviour identical.

Decomposition:
- Shared package ifetch_pkg:
  - FETCH_RUN/FETCH_END/FETCH_FAULT state encodings
  - INSTR_W=32, PC_STEP=4
  - the NOP encoding 32'h0000_0013 for bench use
- One sub-module: ifetch_queue (synchronous FIFO of {pc, instr}).
  - Push, pop, flush and count, with flush dominant.
  - Instantiated once; the controller keeps the PC and state machine.

Test Plan:
- Straight line, ROM words at 0..12, dec_ready=1 from reset -> dec_pc 0,4,8,12 on consecutive cycles from cycle 1; no bubbles.
- Backpressure: dec_ready=0 for 6 cycles -> count reaches 4, imem_addr holds 16. Then dec_ready=1 -> pc resumes 16,20 with no lost or duplicated PCs.
- Redirect: redir_valid with redir_pc=0x30 while queue holds 3 entries -> queue flushed, dec_pc=0x30 exactly 2 cycles later, followed by 0x34.
- End of image, ROM_BYTES=128 -> last dec_pc=0x7C, fetch_state=END, dec_valid falls after drain. A redirect to 0x00 returns to RUN.
- Fault: redir_pc=0x32, then redir_pc=0x80 -> FAULT with fault_pc=0x32, then 0x80, dec_valid=0. A redirect to 0x10 recovers.
- Reset asserted mid-stream with full queue -> all outputs are at reset values in the same cycle, and the first dec_pc after release = RESET_PC.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Latency: n/a. Backpressure: n/a.
package ifetch_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH_RUN   = 2'b00,
        FETCH_END   = 2'b01,
        FETCH_FAULT = 2'b10
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_ent_t;

    // Saturating 32-bit add for event counters.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Prefetch FIFO of {pc, instr}; head is combinational, reads zero when empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: caller must not push when full without a same-cycle pop; flush dominates push/pop.
module ifetch_queue
    import ifetch_pkg::*;
#(
    parameter int QDEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [31:0]               push_pc,
    input  logic [INSTR_W-1:0]        push_instr,
    input  logic                      pop,
    input  logic                      flush,
    output logic [$clog2(QDEPTH):0]   count,
    output logic                      empty,
    output logic [31:0]               head_pc,
    output logic [INSTR_W-1:0]        head_instr
);

    localparam int AW = $clog2(QDEPTH);

    fetch_ent_t    mem [QDEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
        end
    end

    assign empty      = (count == '0);
    assign head_pc    = empty ? 32'd0 : mem[rd_ptr].pc;
    assign head_instr = empty ? '0    : mem[rd_ptr].instr;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch sequencer: owns the PC, fetches from a combinational ROM into a prefetch queue, handles redirects.
// Latency: fetched word appears at dec_* one cycle after fetch; redirect target two cycles after redir_valid.
// Backpressure: dec_ready low fills the queue, then the PC holds. Optional counters under IFETCH_PERF_EN.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_BYTES = 128,
    parameter int          QDEPTH    = 4
) (
    input  logic               clk,
    input  logic               reset,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic               redir_valid,
    input  logic [31:0]        redir_pc,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [31:0]        dec_pc,
    output logic [1:0]         fetch_state,
    output logic [31:0]        fault_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed,
    output logic [31:0]        perf_stall
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t  state, state_nxt;
    logic [31:0]   pc, pc_nxt, fault_pc_nxt;
    logic          push, pop, flush, room, q_empty;
    logic [CW-1:0] q_count;

    // 33-bit compare so a PC near the top of the address space cannot wrap into range.
    function automatic logic fits(input logic [31:0] a);
        return ({1'b0, a} + 33'd4) <= 33'(ROM_BYTES);
    endfunction

    assign imem_addr   = pc;
    assign dec_valid   = !q_empty;
    assign pop         = dec_valid && dec_ready;
    assign room        = (q_count < CW'(QDEPTH)) || pop;
    assign fetch_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= FETCH_RUN;
            pc       <= RESET_PC;
            fault_pc <= 32'd0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            fault_pc <= fault_pc_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        fault_pc_nxt = fault_pc;
        push         = 1'b0;
        flush        = 1'b0;
        if (redir_valid) begin
            flush = 1'b1;
            if (redir_pc[1:0] != 2'b00 || !fits(redir_pc)) begin
                state_nxt    = FETCH_FAULT;
                fault_pc_nxt = redir_pc;
            end else begin
                state_nxt = FETCH_RUN;
                pc_nxt    = redir_pc;
            end
        end else if (state == FETCH_RUN) begin
            if (!fits(pc)) begin
                state_nxt = FETCH_END;
            end else if (room) begin
                push   = 1'b1;
                pc_nxt = pc + PC_STEP;
            end
        end
    end

    ifetch_queue #(.QDEPTH(QDEPTH)) u_queue (
        .clk        (clk),
        .rst        (reset),
        .push       (push),
        .push_pc    (pc),
        .push_instr (imem_instr),
        .pop        (pop),
        .flush      (flush),
        .count      (q_count),
        .empty      (q_empty),
        .head_pc    (dec_pc),
        .head_instr (dec_instr)
    );

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= 32'd0;
            perf_flushed <= 32'd0;
            perf_stall   <= 32'd0;
        end else begin
            if (push)
                perf_fetched <= sat_add(perf_fetched, 32'd1);
            if (redir_valid)
                perf_flushed <= sat_add(perf_flushed, 32'(q_count));
            if (!dec_valid && state == FETCH_RUN)
                perf_stall <= sat_add(perf_stall, 32'd1);
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl against a byte-array ROM model holding 0xC0DE0000|addr per word.
module tb_ifetch_ctrl;
    import ifetch_pkg::*;

    localparam int ROM_BYTES = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redir_valid = 1'b0;
    logic [31:0] redir_pc = 32'd0;
    logic        dec_valid;
    logic        dec_ready = 1'b0;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [1:0]  fetch_state;
    logic [31:0] fault_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

    logic [7:0] rom [ROM_BYTES];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ifetch_ctrl #(.RESET_PC(32'h0), .ROM_BYTES(ROM_BYTES), .QDEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_addr   (imem_addr),
        .imem_instr  (imem_instr),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_instr   (dec_instr),
        .dec_pc      (dec_pc),
        .fetch_state (fetch_state),
        .fault_pc    (fault_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
        .perf_stall  (perf_stall)
`endif
    );

    // Little-endian combinational ROM; out-of-image reads return NOP.
    always_comb begin
        imem_instr = NOP_INSTR;
        if (imem_addr <= 32'd124)
            imem_instr = {rom[imem_addr[6:0] + 7'd3], rom[imem_addr[6:0] + 7'd2],
                          rom[imem_addr[6:0] + 7'd1], rom[imem_addr[6:0]]};
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hC0DE_0000 | a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_head(input string tag, input logic [31:0] pc);
        chk({tag, "_vld"}, 32'(dec_valid), 32'd1);
        chk({tag, "_pc"}, dec_pc, pc);
        chk({tag, "_instr"}, dec_instr, word_at(pc));
    endtask

    // Asserts reset (async), checks reset values immediately, releases #1 after a rising edge.
    task automatic do_reset();
        reset       = 1'b1;
        redir_valid = 1'b0;
        dec_ready   = 1'b0;
        #2;
        chk("rst_vld", 32'(dec_valid), 32'd0);
        chk("rst_pc", dec_pc, 32'd0);
        chk("rst_instr", dec_instr, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_state", 32'(fetch_state), 32'd0);
        chk("rst_fault", fault_pc, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        for (int a = 0; a < ROM_BYTES; a += 4) begin
            w = word_at(32'(a));
            rom[a]   = w[7:0];
            rom[a+1] = w[15:8];
            rom[a+2] = w[23:16];
            rom[a+3] = w[31:24];
        end

        // Straight line, no bubbles.
        do_reset();
        dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_head("s1", 32'(4 * i));
        end

        // Backpressure: queue fills, PC holds at 16, then resumes without loss.
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        expect_head("s2_full", 32'h0);
        chk("s2_addr_hold", imem_addr, 32'd16);
        dec_ready = 1'b1;
        tick();
        expect_head("s2_resume", 32'd4);
        chk("s2_addr_resume", imem_addr, 32'd20);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_head("s2_seq", 32'(8 + 4 * i));
        end

        // Redirect with three entries queued.
        do_reset();
        for (int i = 0; i < 3; i++) tick();
        chk("s3_pre_addr", imem_addr, 32'd12);
        redir_valid = 1'b1;
        redir_pc    = 32'h30;
        tick();
        redir_valid = 1'b0;
        chk("s3_flushed", 32'(dec_valid), 32'd0);
        chk("s3_addr", imem_addr, 32'h30);
        tick();
        expect_head("s3_tgt", 32'h30);
        dec_ready = 1'b1;
        tick();
        expect_head("s3_next", 32'h34);

        // End of image, then recovery by redirect to 0.
        do_reset();
        dec_ready   = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 32'h70;
        tick();
        redir_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_head("s4_tail", 32'(32'h70 + 4 * i));
        end
        chk("s4_run", 32'(fetch_state), 32'(FETCH_RUN));
        tick();
        chk("s4_end", 32'(fetch_state), 32'(FETCH_END));
        chk("s4_drained", 32'(dec_valid), 32'd0);
        tick();
        chk("s4_end_hold", imem_addr, 32'h80);
        redir_valid = 1'b1;
        redir_pc    = 32'h0;
        tick();
        redir_valid = 1'b0;
        chk("s4_rerun", 32'(fetch_state), 32'(FETCH_RUN));
        tick();
        expect_head("s4_restart", 32'h0);

        // Faults: misaligned, then out of range, then recovery.
        do_reset();
        dec_ready   = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 32'h32;
        tick();
        chk("s5_state_a", 32'(fetch_state), 32'(FETCH_FAULT));
        chk("s5_fpc_a", fault_pc, 32'h32);
        chk("s5_vld_a", 32'(dec_valid), 32'd0);
        chk("s5_pc_kept", imem_addr, 32'h0);
        redir_pc = 32'h80;
        tick();
        redir_valid = 1'b0;
        chk("s5_state_b", 32'(fetch_state), 32'(FETCH_FAULT));
        chk("s5_fpc_b", fault_pc, 32'h80);
        tick();
        chk("s5_vld_idle", 32'(dec_valid), 32'd0);
        chk("s5_addr_idle", imem_addr, 32'h0);
        redir_valid = 1'b1;
        redir_pc    = 32'h10;
        tick();
        redir_valid = 1'b0;
        chk("s5_recover", 32'(fetch_state), 32'(FETCH_RUN));
        tick();
        expect_head("s5_tgt", 32'h10);

        // Reset mid-stream with a full queue.
        for (int i = 0; i < 2; i++) tick();
        dec_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("s6_pre_vld", 32'(dec_valid), 32'd1);
        do_reset();
        dec_ready = 1'b1;
        tick();
        expect_head("s6_first", 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
